// File: rtl/cdb_broadcast_arb_pkg.sv
// Shared CDB/FU types and sizing for the complete stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: CDB_T_PACKET (tags seen by the RS), CDB_PACKET (one broadcast
// slot), FU_RESULT_PACKET (one FU result), FU index constants, and a
// one-hot to index helper.
package sys_defs;

  localparam int NUM_FU = 8;  // must stay a power of two: pick indices wrap by truncation
  localparam int CDB_W  = 3;
  localparam int PR_W   = 6;
  localparam int XLEN   = 32;
  localparam int PTR_W  = $clog2(NUM_FU);

  localparam int FU_ALU1   = 0;
  localparam int FU_ALU2   = 1;
  localparam int FU_ALU3   = 2;
  localparam int FU_LS1    = 3;
  localparam int FU_LS2    = 4;
  localparam int FU_MULT1  = 5;
  localparam int FU_MULT2  = 6;
  localparam int FU_BRANCH = 7;

  // Wake-up tags as the RS sees them; t0 is slot 0.
  typedef struct packed {
    logic [PR_W-1:0] t2;
    logic [PR_W-1:0] t1;
    logic [PR_W-1:0] t0;
  } CDB_T_PACKET;

  typedef struct packed {
    logic            valid;
    logic [PR_W-1:0] tag;
    logic [XLEN-1:0] value;
  } CDB_PACKET;

  typedef struct packed {
    logic            valid;
    logic [PR_W-1:0] dest_pr;
    logic [XLEN-1:0] value;
  } FU_RESULT_PACKET;

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_FU-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (oh[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cdb_broadcast_arb_rr_pick.sv
// Rotating-priority picker: up to CDB_W one-hot grants from NUM_FU requests.
// Latency: purely combinational.
// Backpressure: requests beyond CDB_W simply receive no grant.
// Ports: req (NUM_FU request bits), ptr (first index scanned),
//        grant (per-slot one-hot grant vector), grant_vld (per-slot valid).
module cdb_rr_pick
  import sys_defs::*;
(
  input  logic [NUM_FU-1:0]             req,
  input  logic [PTR_W-1:0]              ptr,
  output logic [CDB_W-1:0][NUM_FU-1:0]  grant,
  output logic [CDB_W-1:0]              grant_vld
);

  logic [PTR_W-1:0] idx;
  int               slot;

  // Walk indices ptr, ptr+1, ... (wrapping by PTR_W truncation) and hand
  // each requester the next free slot in scan order.
  always_comb begin
    grant     = '0;
    grant_vld = '0;
    idx       = '0;
    slot      = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = ptr + PTR_W'(k);
      if (req[idx] && (slot < CDB_W)) begin
        grant[slot][idx] = 1'b1;
        grant_vld[slot]  = 1'b1;
        slot             = slot + 1;
      end
    end
  end

endmodule

// File: rtl/cdb_broadcast_arb.sv
// Complete-stage arbiter: picks up to CDB_W FU results per cycle onto the CDB.
// Latency: result registered onto the CDB one cycle after its fu_ack.
// Backpressure: unpicked FUs stay unacked and hold their result; flush acks nothing.
// Ports: clock/reset (sync, active-high), flush, fu_valid/fu_dest_pr/fu_value
//        per FU, fu_ack (combinational), cdb_valid/cdb_t/cdb_value (registered).
// Config: CDB_RR_PRIORITY_EN defined -> rotating priority pointer;
//         undefined -> fixed priority with index 0 highest (no pointer flop).
module cdb_broadcast_arb
  import sys_defs::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*PR_W-1:0]   fu_dest_pr,
  input  logic [NUM_FU*XLEN-1:0]   fu_value,
  output logic [NUM_FU-1:0]        fu_ack,
  output logic [CDB_W-1:0]         cdb_valid,
  output CDB_T_PACKET              cdb_t,
  output logic [CDB_W*XLEN-1:0]    cdb_value
);

  FU_RESULT_PACKET               fu_res [NUM_FU];
  logic [CDB_W-1:0][NUM_FU-1:0]  grant;
  logic [CDB_W-1:0]              grant_vld;
  logic [NUM_FU-1:0]             granted;
  logic [PTR_W-1:0]              ptr;
  CDB_PACKET                     slot_nxt [CDB_W];
  CDB_PACKET                     cdb_q    [CDB_W];

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_res[i].valid   = fu_valid[i];
      fu_res[i].dest_pr = fu_dest_pr[i*PR_W +: PR_W];
      fu_res[i].value   = fu_value[i*XLEN +: XLEN];
    end
  end

  cdb_rr_pick u_pick (
    .req       (fu_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  always_comb begin
    granted = '0;
    for (int s = 0; s < CDB_W; s++) granted = granted | grant[s];
  end

  assign fu_ack = fu_valid & granted & {NUM_FU{~flush & ~reset}};

  // AND-OR slot muxes; grants are one-hot so at most one term is live.
  // Tag 0 (no destination) passes through with valid set.
  always_comb begin
    for (int s = 0; s < CDB_W; s++) begin
      slot_nxt[s]       = '0;
      slot_nxt[s].valid = grant_vld[s];
      for (int i = 0; i < NUM_FU; i++) begin
        if (grant[s][i] && fu_res[i].valid) begin
          slot_nxt[s].tag   = fu_res[i].dest_pr;
          slot_nxt[s].value = fu_res[i].value;
        end
      end
    end
  end

`ifdef CDB_RR_PRIORITY_EN
  logic [NUM_FU-1:0] last_oh;
  logic              any_grant;
  logic [PTR_W-1:0]  ptr_q;

  // The highest filled slot holds the last index granted in scan order.
  always_comb begin
    last_oh   = '0;
    any_grant = |grant_vld;
    for (int s = 0; s < CDB_W; s++) begin
      if (grant_vld[s]) last_oh = grant[s];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (!flush && any_grant) begin
      ptr_q <= onehot_to_idx(last_oh) + PTR_W'(1);
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  // Unfilled slots load all-zero, so an invalid slot always shows tag 0.
  always_ff @(posedge clock) begin
    for (int s = 0; s < CDB_W; s++) begin
      if (reset || flush) cdb_q[s] <= '0;
      else                cdb_q[s] <= slot_nxt[s];
    end
  end

  always_comb begin
    for (int s = 0; s < CDB_W; s++) begin
      cdb_valid[s]               = cdb_q[s].valid;
      cdb_value[s*XLEN +: XLEN]  = cdb_q[s].value;
    end
    cdb_t.t0 = cdb_q[0].tag;
    cdb_t.t1 = cdb_q[1].tag;
    cdb_t.t2 = cdb_q[2].tag;
  end

endmodule

// File: tb/tb_cdb_broadcast_arb.sv
// Directed bench for cdb_broadcast_arb with a queue-based scoreboard.
// Stimulus pushes the expected fu_ack for the current cycle and the expected
// CDB contents for the next cycle; a monitor on the falling edge compares.
module tb_cdb_broadcast_arb;
  import sys_defs::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [7:0]  fu_valid = '0;
  logic [5:0]  dest [8];
  logic [31:0] val  [8];
  logic [47:0]  fu_dest_pr;
  logic [255:0] fu_value;
  logic [7:0]   fu_ack;
  logic [2:0]   cdb_valid;
  CDB_T_PACKET  cdb_t;
  logic [95:0]  cdb_value;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 8; g++) begin : g_pack
    assign fu_dest_pr[g*6 +: 6]  = dest[g];
    assign fu_value[g*32 +: 32]  = val[g];
  end

  cdb_broadcast_arb dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .fu_valid   (fu_valid),
    .fu_dest_pr (fu_dest_pr),
    .fu_value   (fu_value),
    .fu_ack     (fu_ack),
    .cdb_valid  (cdb_valid),
    .cdb_t      (cdb_t),
    .cdb_value  (cdb_value)
  );

  typedef struct {
    int         cyc;
    logic [7:0] ack;
  } ack_exp_t;

  typedef struct {
    int          cyc;
    logic [2:0]  vld;
    logic [17:0] t;
    logic [95:0] v;
  } cdb_exp_t;

  ack_exp_t ack_q [$];
  cdb_exp_t cdb_q [$];
  ack_exp_t a_cur;
  cdb_exp_t c_cur;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the expectation belonging to this cycle and compares.
  always @(negedge clock) begin
    logic [95:0] m;
    if (ack_q.size() > 0 && ack_q[0].cyc <= cyc) begin
      a_cur = ack_q.pop_front();
      if (a_cur.cyc != cyc) check("ack_missed", 96'(cyc), 96'(a_cur.cyc));
      else                  check("fu_ack", 96'(fu_ack), 96'(a_cur.ack));
    end
    if (cdb_q.size() > 0 && cdb_q[0].cyc <= cyc) begin
      c_cur = cdb_q.pop_front();
      if (c_cur.cyc != cyc) begin
        check("cdb_missed", 96'(cyc), 96'(c_cur.cyc));
      end else begin
        m = '0;
        for (int s = 0; s < 3; s++) m[s*32 +: 32] = {32{c_cur.vld[s]}};
        check("cdb_valid", 96'(cdb_valid), 96'(c_cur.vld));
        check("cdb_t", 96'(cdb_t), 96'(c_cur.t));
        check("cdb_value", cdb_value & m, c_cur.v & m);
      end
    end else if (started && cdb_q.size() == 0 && cdb_valid !== 3'b000) begin
      check("cdb_unexpected", 96'(cdb_valid), 96'(0));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic rst, input logic fl, input logic [7:0] vld,
                       input logic [7:0] eack, input logic [2:0] ecv,
                       input logic [5:0] e0, input logic [5:0] e1, input logic [5:0] e2,
                       input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    reset    = rst;
    flush    = fl;
    fu_valid = vld;
    started  = 1'b1;
    ack_q.push_back('{cyc: cyc, ack: eack});
    cdb_q.push_back('{cyc: cyc + 1, vld: ecv, t: {e2, e1, e0}, v: {w2, w1, w0}});
  endtask

  task automatic vec(input logic rst, input logic fl, input logic [7:0] vld,
                     input logic [7:0] eack, input logic [2:0] ecv,
                     input logic [5:0] e0, input logic [5:0] e1, input logic [5:0] e2,
                     input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    tick();
    issue(rst, fl, vld, eack, ecv, e0, e1, e2, w0, w1, w2);
  endtask

  localparam logic [31:0] V0 = 32'hA000_0000, V1 = 32'hA000_0001, V2 = 32'hA000_0002,
                          V3 = 32'hA000_0003, V4 = 32'hA000_0004, V5 = 32'hA000_0005,
                          V6 = 32'hA000_0006, V7 = 32'hA000_0007;

  initial begin
    for (int i = 0; i < 8; i++) begin
      dest[i] = 6'(10 + i);
      val[i]  = 32'hA000_0000 + 32'(i);
    end
    repeat (2) @(posedge clock);

    // Reset held with every FU requesting: no acks, CDB clear.
    repeat (2) vec(1, 0, 8'hFF, 8'h00, 3'b000, 0, 0, 0, 0, 0, 0);
    // Idle after reset.
    repeat (5) vec(0, 0, 8'h00, 8'h00, 3'b000, 0, 0, 0, 0, 0, 0);

    // Single result from FU0.
    dest[0] = 6'd5; val[0] = 32'h0000_DEAD;
    vec(0, 0, 8'h01, 8'h01, 3'b001, 5, 0, 0, 32'h0000_DEAD, 0, 0);
    vec(0, 0, 8'h01, 8'h01, 3'b001, 5, 0, 0, 32'h0000_DEAD, 0, 0);

    // Reset mid-operation: pointer back to 0, CDB clear.
    tick();
    dest[0] = 6'd10; val[0] = V0;
    issue(1, 0, 8'hFF, 8'h00, 3'b000, 0, 0, 0, 0, 0, 0);

    // All eight FUs requesting continuously.
`ifdef CDB_RR_PRIORITY_EN
    vec(0, 0, 8'hFF, 8'h07, 3'b111, 10, 11, 12, V0, V1, V2);
    vec(0, 0, 8'hFF, 8'h38, 3'b111, 13, 14, 15, V3, V4, V5);
    vec(0, 0, 8'hFF, 8'hC1, 3'b111, 16, 17, 10, V6, V7, V0);
    vec(0, 0, 8'hFF, 8'h0E, 3'b111, 11, 12, 13, V1, V2, V3);
`else
    repeat (4) vec(0, 0, 8'hFF, 8'h07, 3'b111, 10, 11, 12, V0, V1, V2);
`endif

    // Two requesters only: third slot empty (pointer lands on 6 in RR mode).
    vec(0, 0, 8'h30, 8'h30, 3'b011, 14, 15, 0, V4, V5, 0);

    // Wrap-around from pointer 6 with requesters {7,0,1,2}.
`ifdef CDB_RR_PRIORITY_EN
    vec(0, 0, 8'h87, 8'h83, 3'b111, 17, 10, 11, V7, V0, V1);
`else
    vec(0, 0, 8'h87, 8'h07, 3'b111, 10, 11, 12, V0, V1, V2);
`endif

    vec(0, 0, 8'h08, 8'h08, 3'b001, 13, 0, 0, V3, 0, 0);

    // Flush: nothing acked, CDB cleared, pointer holds.
    vec(0, 1, 8'h0F, 8'h00, 3'b000, 0, 0, 0, 0, 0, 0);
    vec(0, 0, 8'h0F, 8'h07, 3'b111, 10, 11, 12, V0, V1, V2);
`ifdef CDB_RR_PRIORITY_EN
    vec(0, 0, 8'h0F, 8'h0B, 3'b111, 13, 10, 11, V3, V0, V1);
`else
    vec(0, 0, 8'h0F, 8'h07, 3'b111, 10, 11, 12, V0, V1, V2);
`endif

    // Bring pointer to 0, then a no-destination result beside a real one.
    vec(0, 0, 8'h80, 8'h80, 3'b001, 17, 0, 0, V7, 0, 0);
    tick();
    dest[0] = 6'd9; dest[7] = 6'd0;
    issue(0, 0, 8'h81, 8'h81, 3'b011, 9, 0, 0, V0, V7, 0);

    repeat (2) vec(0, 0, 8'h00, 8'h00, 3'b000, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clock);
    checks++;
    if (ack_q.size() != 0 || cdb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending_ack=%0d pending_cdb=%0d required=0", ack_q.size(), cdb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
